// File: rtl/f1_lights_monitor.sv
// Start-light monitor: follows the thermometer-coded light bus and times the driver's reaction after lights-out.
// It also flags jump starts, missed launches and malformed light sequences.
module f1_lights_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [7:0]       lights,
  input  logic             trigger,
  output logic [3:0]       lit_cnt,
  output logic [CNT_W-1:0] react_time,
  output logic             time_valid,
  output logic             jump_start,
  output logic             miss,
  output logic             fault
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMING,
    ST_FULL,
    ST_RUN,
    ST_DONE,
    ST_JUMP,
    ST_MISS,
    ST_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [7:0]       prev;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [CNT_W-1:0] react_nxt;
  logic [3:0]       lit_nxt;
  logic             tv_nxt, js_nxt, miss_nxt, fault_nxt;
  logic             zero_seen, zero_nxt;
  logic             lights_therm, step_ok;
  logic [CNT_W-1:0] cnt_inc, cnt_ticked;

  function automatic logic is_therm(input logic [7:0] v);
    return (v & (v + 8'd1)) == 8'd0;
  endfunction

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // A legal step either holds the pattern or lights exactly one more lamp.
  assign lights_therm = is_therm(lights);
  assign step_ok      = lights_therm && ((lights == prev) || (lights == {prev[6:0], 1'b1}));
  assign cnt_inc      = (counter == CNT_MAX) ? counter : counter + CNT_ONE;
  assign cnt_ticked   = tick ? cnt_inc : counter;

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    react_nxt   = react_time;
    tv_nxt      = time_valid;
    js_nxt      = jump_start;
    miss_nxt    = miss;
    fault_nxt   = fault;
    zero_nxt    = 1'b0;
    lit_nxt     = lights_therm ? popcnt(lights) : 4'hF;

    case (state)
      ST_IDLE: begin
        if (lights == 8'h01) begin
          state_nxt = ST_ARMING;
        end else if (lights != 8'h00) begin
          state_nxt = ST_FAULT;
          fault_nxt = 1'b1;
        end
      end

      ST_ARMING: begin
        if (trigger) begin
          state_nxt = ST_JUMP;
          js_nxt    = 1'b1;
        end else if (!step_ok || lights == 8'h00) begin
          state_nxt = ST_FAULT;
          fault_nxt = 1'b1;
        end else if (lights == 8'hFF) begin
          state_nxt = ST_FULL;
        end
      end

      ST_FULL: begin
        if (trigger) begin
          state_nxt = ST_JUMP;
          js_nxt    = 1'b1;
        end else if (lights == 8'h00) begin
          state_nxt   = ST_RUN;
          counter_nxt = '0;
        end else if (lights != 8'hFF) begin
          state_nxt = ST_FAULT;
          fault_nxt = 1'b1;
        end
      end

      // The tick landing in the trigger cycle still counts toward the result.
      ST_RUN: begin
        counter_nxt = cnt_ticked;
        if (trigger) begin
          state_nxt = ST_DONE;
          react_nxt = cnt_ticked;
          tv_nxt    = 1'b1;
        end else if (lights == 8'h01) begin
          state_nxt = ST_MISS;
          miss_nxt  = 1'b1;
        end else if (lights != 8'h00) begin
          state_nxt = ST_FAULT;
          fault_nxt = 1'b1;
        end
      end

      ST_DONE, ST_JUMP, ST_MISS: begin
        if (lights == 8'h01) begin
          state_nxt = ST_ARMING;
          tv_nxt    = 1'b0;
          js_nxt    = 1'b0;
          miss_nxt  = 1'b0;
        end
      end

      // Leaving needs two back-to-back 0x00 samples taken while in this state.
      ST_FAULT: begin
        if (lights == 8'h00) begin
          if (zero_seen) begin
            state_nxt = ST_IDLE;
            fault_nxt = 1'b0;
          end else begin
            zero_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prev       <= 8'h00;
      counter    <= '0;
      lit_cnt    <= 4'd0;
      react_time <= '0;
      time_valid <= 1'b0;
      jump_start <= 1'b0;
      miss       <= 1'b0;
      fault      <= 1'b0;
      zero_seen  <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= lights;
      counter    <= counter_nxt;
      lit_cnt    <= lit_nxt;
      react_time <= react_nxt;
      time_valid <= tv_nxt;
      jump_start <= js_nxt;
      miss       <= miss_nxt;
      fault      <= fault_nxt;
      zero_seen  <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_f1_lights_monitor.sv
// Scoreboard bench for f1_lights_monitor: directed light sequences push expected outputs,
// a negedge monitor pops and compares them. A CNT_W=4 copy shares the stimulus for saturation.
module tb_f1_lights_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        trigger;
  logic [7:0]  lights;

  logic [3:0]  lit_cnt, lit_cnt4;
  logic [15:0] react_time;
  logic [3:0]  react_time4;
  logic        time_valid, jump_start, miss, fault;
  logic        time_valid4, jump_start4, miss4, fault4;

  f1_lights_monitor #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .lights(lights), .trigger(trigger),
    .lit_cnt(lit_cnt), .react_time(react_time), .time_valid(time_valid),
    .jump_start(jump_start), .miss(miss), .fault(fault)
  );

  f1_lights_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .lights(lights), .trigger(trigger),
    .lit_cnt(lit_cnt4), .react_time(react_time4), .time_valid(time_valid4),
    .jump_start(jump_start4), .miss(miss4), .fault(fault4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [3:0]  lit;
    logic [15:0] rt;
    logic        tv;
    logic        js;
    logic        ms;
    logic        ft;
    bit          chk4;
    logic [3:0]  rt4;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;

  task automatic applyStimulus(input logic [7:0] l, input logic tr, input logic tk);
    lights  = l;
    trigger = tr;
    tick    = tk;
    @(posedge clk);
    #1;
  endtask

  function automatic void pushExpect(string name, logic [3:0] lit, logic [15:0] rt,
                                     logic tv, logic js, logic ms, logic ft,
                                     bit chk4, logic [3:0] rt4);
    exp_t e;
    e.cyc = cyc; e.name = name; e.lit = lit; e.rt = rt;
    e.tv = tv; e.js = js; e.ms = ms; e.ft = ft; e.chk4 = chk4; e.rt4 = rt4;
    sb.push_back(e);
  endfunction

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({lit_cnt, react_time, time_valid, jump_start, miss, fault} !==
        {e.lit, e.rt, e.tv, e.js, e.ms, e.ft}) begin
      failures++;
      $display("[TB] FAIL %s @cyc %0d: got lit=%h rt=%0d tv=%b js=%b miss=%b fault=%b, want lit=%h rt=%0d tv=%b js=%b miss=%b fault=%b",
               e.name, e.cyc, lit_cnt, react_time, time_valid, jump_start, miss, fault,
               e.lit, e.rt, e.tv, e.js, e.ms, e.ft);
    end
    if (e.chk4) begin
      checks++;
      if (react_time4 !== e.rt4) begin
        failures++;
        $display("[TB] FAIL %s_w4 @cyc %0d: got rt=%0d, want rt=%0d", e.name, e.cyc, react_time4, e.rt4);
      end
    end
  endtask

  // Steps lights from lamp count 'first' up to 0xFF, one step per cycle.
  task automatic climbFrom(input int first);
    logic [8:0] v;
    for (int i = first; i <= 8; i++) begin
      v = (9'd1 << i) - 9'd1;
      applyStimulus(v[7:0], 1'b0, 1'b0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        cur = sb.pop_front();
        checkOutput(cur);
      end
    end
  end

  initial begin
    logic [8:0] v;
    rst_n = 1'b0; lights = 8'h00; trigger = 1'b0; tick = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    pushExpect("reset", 4'd0, 16'd0, 0, 0, 0, 0, 1, 4'd0);
    rst_n = 1'b1;

    // Normal launch: each step held 4 cycles, then 37 ticks and a trigger.
    for (int i = 1; i <= 8; i++) begin
      v = (9'd1 << i) - 9'd1;
      repeat (4) applyStimulus(v[7:0], 1'b0, 1'b0);
      pushExpect("climb", 4'(i), 16'd0, 0, 0, 0, 0, 0, 4'd0);
    end
    applyStimulus(8'h00, 1'b0, 1'b0);
    pushExpect("run_entry", 4'd0, 16'd0, 0, 0, 0, 0, 0, 4'd0);
    repeat (37) applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    pushExpect("done_37", 4'd0, 16'd37, 1, 0, 0, 0, 1, 4'd15);
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    pushExpect("done_hold", 4'd0, 16'd37, 1, 0, 0, 0, 0, 4'd0);

    // Jump start on 0x07.
    applyStimulus(8'h01, 1'b0, 1'b0);
    pushExpect("rearm_clear_tv", 4'd1, 16'd37, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b1, 1'b0);
    pushExpect("jump", 4'd3, 16'd37, 0, 1, 0, 0, 0, 4'd0);
    applyStimulus(8'h0F, 1'b0, 1'b0);
    pushExpect("jump_hold", 4'd4, 16'd37, 0, 1, 0, 0, 0, 4'd0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    pushExpect("jump_clear", 4'd1, 16'd37, 0, 0, 0, 0, 0, 4'd0);

    // Missed launch, then re-arm.
    climbFrom(2);
    repeat (10) applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h01, 1'b0, 1'b0);
    pushExpect("miss", 4'd1, 16'd37, 0, 0, 1, 0, 0, 4'd0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    pushExpect("miss_clear", 4'd1, 16'd37, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    pushExpect("rearm_after_miss", 4'd2, 16'd37, 0, 0, 0, 0, 0, 4'd0);

    // 20 ticks: full width reads 20, 4-bit copy saturates at 15.
    climbFrom(3);
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (20) applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    pushExpect("sat", 4'd0, 16'd20, 1, 0, 0, 0, 1, 4'd15);

    // Trigger and tick together with counter at 5.
    applyStimulus(8'h01, 1'b0, 1'b0);
    pushExpect("rearm2", 4'd1, 16'd20, 0, 0, 0, 0, 0, 4'd0);
    climbFrom(2);
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (5) applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b1);
    pushExpect("trig_tick", 4'd0, 16'd6, 1, 0, 0, 0, 1, 4'd6);

    // Illegal step 0x01 -> 0x05, then recovery.
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b0, 1'b0);
    pushExpect("fault", 4'hF, 16'd6, 0, 0, 0, 1, 0, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    pushExpect("fault_hold", 4'd0, 16'd6, 0, 0, 0, 1, 0, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    pushExpect("fault_exit", 4'd0, 16'd6, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    pushExpect("idle_trig_ignored", 4'd0, 16'd6, 0, 0, 0, 0, 0, 4'd0);

    // Zero samples must be consecutive to leave the fault state.
    applyStimulus(8'h03, 1'b0, 1'b0);
    pushExpect("idle_fault", 4'd2, 16'd6, 0, 0, 0, 1, 0, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    pushExpect("fault_nonconsec", 4'd0, 16'd6, 0, 0, 0, 1, 0, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    pushExpect("fault_exit2", 4'd0, 16'd6, 0, 0, 0, 0, 0, 4'd0);

    // Reset mid-RUN beats a simultaneous trigger.
    applyStimulus(8'h01, 1'b0, 1'b0);
    climbFrom(2);
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (3) applyStimulus(8'h00, 1'b0, 1'b1);
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b1, 1'b1);
    pushExpect("reset_mid_run", 4'd0, 16'd0, 0, 0, 0, 0, 1, 4'd0);
    rst_n = 1'b1;
    applyStimulus(8'h03, 1'b0, 1'b0);
    pushExpect("post_reset_03", 4'd2, 16'd0, 0, 0, 0, 1, 0, 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    pushExpect("post_reset_clear", 4'd0, 16'd0, 0, 0, 0, 0, 0, 4'd0);

    rst_n = 1'b0;
    applyStimulus(8'h55, 1'b0, 1'b0);
    pushExpect("reset2", 4'd0, 16'd0, 0, 0, 0, 0, 0, 4'd0);
    rst_n = 1'b1;
    applyStimulus(8'h01, 1'b0, 1'b0);
    pushExpect("post_reset_01", 4'd1, 16'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    pushExpect("post_reset_arming", 4'd2, 16'd0, 0, 0, 0, 0, 0, 4'd0);

    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f1_lights_monitor.md
F1_LIGHTS_MONITOR -- requirements
Module: f1_lights_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of the reaction-time counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 tick  input  1  one-cycle timebase strobe; one strobe is one reaction-time unit.
REQ-005 lights  input  8  start-light bus from the light-sequence generator, expected thermometer-coded (0x00, 0x01, 0x03 ... 0xFF).
REQ-006 trigger  input  1  driver button, level-sampled each cycle.
REQ-007 lit_cnt  output  4  registered count of lit lamps (0-8).
REQ-008 react_time  output  CNT_W  captured reaction time in ticks.
REQ-009 time_valid  output  1  react_time holds a valid result.
REQ-010 jump_start  output  1  trigger was seen before lights-out.
REQ-011 miss  output  1  sequence restarted with no trigger after lights-out.
REQ-012 fault  output  1  illegal pattern or illegal step seen on lights.

Function
REQ-013 The block SHALL keep prev, a register holding the last sampled lights value; prev updates every cycle.
REQ-014 Legal step: lights == prev, or lights == {prev[6:0],1'b1}; any value that is not a thermometer code SHALL be illegal.
REQ-015 lit_cnt SHALL equal the popcount of the lights value sampled one cycle earlier when that value is a thermometer code, else 4'hF.
REQ-016 States: IDLE, ARMING, FULL, RUN, DONE, JUMP, MISS, FAULT.
REQ-017 IDLE: lights==0x00 -> stay; lights==0x01 -> ARMING; any other value -> FAULT; trigger ignored.
REQ-018 ARMING: trigger -> JUMP; else illegal step or lights==0x00 -> FAULT; else lights==0xFF -> FULL; else stay.
REQ-019 FULL: trigger -> JUMP; else lights==0x00 -> RUN with counter cleared to 0; else lights==0xFF -> stay; else FAULT.
REQ-020 RUN: counter +1 on each tick, saturating at all-ones (no wrap).
REQ-021 RUN: trigger -> DONE; react_time <= counter, plus 1 (saturating) if tick is high in the same cycle; time_valid <= 1.
REQ-022 RUN, no trigger: lights==0x01 -> MISS with miss <= 1; lights==0x00 -> stay; any other value -> FAULT.
REQ-023 DONE, JUMP, MISS: lights==0x01 -> ARMING, clearing time_valid, jump_start and miss in that cycle; otherwise hold state and outputs.
REQ-024 Entry to JUMP SHALL set jump_start=1; react_time is left unchanged.
REQ-025 Entry to FAULT SHALL set fault=1.
REQ-026 FAULT SHALL exit to IDLE only when lights==0x00 has been sampled for 2 consecutive cycles; fault clears on exit.
REQ-027 Precedence on simultaneous events: trigger > fault detection > normal lights transition.
REQ-028 All outputs SHALL be registered; a state change is visible on outputs in the cycle after the causing input is sampled.
REQ-029 react_time SHALL change only on entry to DONE.

Reset
REQ-030 rst_n==0 at a clock edge SHALL force: state IDLE, prev=0x00, counter=0, lit_cnt=0, react_time=0, time_valid=0, jump_start=0, miss=0, fault=0.
REQ-031 Reset asserted mid-sequence, in any state, SHALL take priority over all inputs.
REQ-032 After release, the first sampled lights value SHALL be treated as following prev=0x00.

Verification
REQ-033 Normal run: lights steps 0x01..0xFF one step per 4 cycles, then 0x00; 37 ticks; trigger -> react_time=37, time_valid=1, no flags set.
REQ-034 Jump start: trigger while lights==0x07 -> jump_start=1, time_valid=0, react_time unchanged; next 0x01 clears jump_start.
REQ-035 Miss: full sequence, 0x00 for 10 ticks, then 0x01 with no trigger -> miss=1; state ARMING after the following 0x01->0x03 step.
REQ-036 Fault: lights 0x01 -> 0x05 -> fault=1 and lit_cnt=0xF; two cycles of 0x00 -> fault=0, state IDLE.
REQ-037 Saturation and edge cases: CNT_W=4 with 20 ticks in RUN -> react_time=15. Trigger and tick in the same cycle with counter=5 -> react_time=6.
REQ-038 Reset mid-RUN: rst_n low for 1 cycle -> all outputs 0 the next cycle. A following 0x03 -> FAULT; a following 0x01 -> ARMING.
